btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Parametrised 2-way set-associative branch target buffer.
- Each entry holds a saturating direction counter, so the block predicts both the target and taken/not-taken.
- The fetch stage issues lookups and receives a registered prediction one cycle later.
- The execute stage writes resolved branch outcomes through a dedicated update port; targets are not computed internally.
- Sits beside the fetch PC mux.

Parameters:
- XLEN, 32, PC and target width.
- SETS, 16, number of sets; power of two, ≥2. IDX = log2(SETS).
- CTR_BITS, 2, width of the per-entry saturating counter (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  invalidate all entries.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  XLEN  fetch PC.
- pred_valid  out  1  registered response to the previous cycle's lookup.
- pred_hit  out  1  tag match in either way.
- pred_taken  out  1  hit and counter MSB set.
- pred_target  out  XLEN  stored target; 0 on miss.
- upd_valid  in  1  resolved branch update.
- upd_pc  in  XLEN  branch PC.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual target.

Behaviour:
- Address split:
  - pc[1:0] ignored.
  - index = pc[2 +: IDX].
  - tag = pc[XLEN-1 : 2+IDX].
- Per set: two ways of {valid, tag, target, ctr[CTR_BITS-1:0]} plus one LRU bit naming the way to replace next.
- Reset (async, rst_n=0):
  - All valid bits and LRU bits cleared.
  - pred_valid, pred_hit, pred_taken = 0; pred_target = 0.
  - Tag, target and counter storage need not be reset.
- Lookup, 1-cycle latency:
  - Cycle N: lookup_valid=1.
  - Cycle N+1: pred_valid=1 with hit/taken/target computed from the array state at the start of cycle N.
  - If lookup_valid=0 in cycle N: pred_valid=0 in N+1; other outputs hold 0.
  - Both ways hit (must not occur): way 0 takes priority.
  - A lookup hit sets LRU to the other way.
- Update, applied at the clock edge ending the upd_valid cycle:
  - Hit, taken: ctr increments, saturating at 2^CTR_BITS-1; target <= upd_target; LRU <= other way.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged; LRU <= other way.
  - Miss, taken: allocate. Victim is way 0 if invalid, else way 1 if invalid, else the LRU way. Write valid=1, tag, target, ctr = 2^(CTR_BITS-1) (weakly taken). LRU <= other way.
  - Miss, not taken: no state change.
- Simultaneous lookup and update:
  - The lookup sees pre-update state (read-before-write), including when index and tag match.
  - If both touch the same set's LRU in one cycle, the update's LRU write wins.
- flush:
  - Clears all valid bits and LRU bits at the next edge, overriding any simultaneous update.
  - A lookup in the flush cycle still returns pre-flush contents.
  - The lookup in the following cycle misses.
- Deassertion of rst_n mid-stream: the first lookup accepted after reset misses.
- No backpressure: one lookup and one update may be accepted every cycle.

Test Plan:
1. Reset, then lookup 0x0000_0040 -> N+1: pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
2. Update pc=0x0000_0040 taken, target=0x0000_0100; next cycle lookup 0x40 -> hit=1, taken=1, target=0x100.
   - Then two not-taken updates -> ctr 2→1→0; lookup gives hit=1, taken=0.
   - A third not-taken update keeps ctr=0.
3. Three taken updates to 0x40 from a fresh alloc -> ctr saturates at 3.
   - One not-taken update -> ctr=2; still predicted taken.
4. Conflict, SETS=16: allocate 0x040 (way 0), then 0x440 (way 1); lookup 0x040 (LRU->way 1); allocate 0x840 -> evicts 0x440.
   - Lookups: 0x040 hit, 0x440 miss, 0x840 hit.
5. Same-cycle update alloc of 0x80 and lookup 0x80 -> that response misses; a lookup the next cycle hits.
   - Not-taken update to an absent PC 0xC0 -> later lookup 0xC0 misses.
6. Populate 4 sets, assert flush with a concurrent taken update to 0x200 -> all lookups (including 0x200) miss afterwards.
   - Pull rst_n low mid-stream -> pred_valid drops to 0 immediately (asynchronously).

Source files
------------

// File: rtl/btb_predictor.sv
// 2-way set-associative BTB with per-entry saturating direction counters; registered prediction one cycle after lookup.
// No backpressure: one lookup and one update accepted every cycle; update and flush take effect at the closing edge.
module btb_predictor #(
  parameter int XLEN     = 32,
  parameter int SETS     = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = XLEN - 2 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [SETS-1:0]     valid [2];
  logic [SETS-1:0]     lru;
  logic [TAGW-1:0]     tags    [2][SETS];
  logic [XLEN-1:0]     targets [2][SETS];
  logic [CTR_BITS-1:0] ctrs    [2][SETS];

  logic [IDX-1:0]      l_idx, u_idx;
  logic [TAGW-1:0]     l_tag, u_tag;
  logic                l_hit0, l_hit1, l_hit, l_way;
  logic                u_hit0, u_hit1, u_hit, u_way, u_victim;
  logic                u_write;
  logic [CTR_BITS-1:0] l_ctr, u_ctr;
  logic [XLEN-1:0]     l_target;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign l_idx    = lookup_pc[2 +: IDX];
  assign l_tag    = lookup_pc[XLEN-1 -: TAGW];
  assign l_hit0   = valid[0][l_idx] && (tags[0][l_idx] == l_tag);
  assign l_hit1   = valid[1][l_idx] && (tags[1][l_idx] == l_tag);
  assign l_hit    = l_hit0 || l_hit1;
  // Way 0 wins if both ways ever match.
  assign l_way    = !l_hit0;
  assign l_ctr    = ctrs[l_way][l_idx];
  assign l_target = targets[l_way][l_idx];

  assign u_idx    = upd_pc[2 +: IDX];
  assign u_tag    = upd_pc[XLEN-1 -: TAGW];
  assign u_hit0   = valid[0][u_idx] && (tags[0][u_idx] == u_tag);
  assign u_hit1   = valid[1][u_idx] && (tags[1][u_idx] == u_tag);
  assign u_hit    = u_hit0 || u_hit1;
  assign u_victim = !valid[0][u_idx] ? 1'b0 : (!valid[1][u_idx] ? 1'b1 : lru[u_idx]);
  assign u_way    = u_hit ? !u_hit0 : u_victim;
  assign u_ctr    = ctrs[u_way][u_idx];
  // Not-taken misses never allocate, so they leave all state untouched.
  assign u_write  = upd_valid && (u_hit || upd_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid[0]    <= '0;
      valid[1]    <= '0;
      lru         <= '0;
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= lookup_valid;
      pred_hit    <= lookup_valid && l_hit;
      pred_taken  <= lookup_valid && l_hit && l_ctr[CTR_BITS-1];
      pred_target <= (lookup_valid && l_hit) ? l_target : '0;
      if (flush) begin
        valid[0] <= '0;
        valid[1] <= '0;
        lru      <= '0;
      end else begin
        if (lookup_valid && l_hit) lru[l_idx] <= !l_way;
        // Placed after the lookup write so the update wins on a shared set.
        if (u_write) begin
          lru[u_idx] <= !u_way;
          if (!u_hit) valid[u_way][u_idx] <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (u_write && !flush) begin
      if (u_hit) begin
        if (upd_taken) begin
          ctrs[u_way][u_idx]    <= (u_ctr != CTR_MAX) ? u_ctr + 1'b1 : u_ctr;
          targets[u_way][u_idx] <= upd_target;
        end else begin
          ctrs[u_way][u_idx]    <= (u_ctr != '0) ? u_ctr - 1'b1 : u_ctr;
        end
      end else begin
        tags[u_way][u_idx]    <= u_tag;
        targets[u_way][u_idx] <= upd_target;
        ctrs[u_way][u_idx]    <= CTR_INIT;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: expected predictions queued at lookup time, matched against observed responses.
module tb_btb_predictor;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  int tests = 0;
  int fails = 0;
  pred_t exp_q[$];
  pred_t obs_q[$];

  btb_predictor #(.XLEN(32), .SETS(16), .CTR_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && pred_valid) obs_q.push_back('{hit: pred_hit, taken: pred_taken, target: pred_target});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic cyc(input logic lv, input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utgt, input logic fl);
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    flush = fl;
    @(posedge clk); #1;
    lookup_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic lk(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tgt);
    exp_q.push_back('{hit: h, taken: t, target: tgt});
    cyc(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic up(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    cyc(1'b0, '0, 1'b1, pc, t, tgt, 1'b0);
  endtask

  task automatic do_flush();
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    pred_t e, o;
    #12;
    tests++;
    if ({pred_valid, pred_hit, pred_taken, pred_target} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b h=%b t=%b tgt=%h, want all 0", pred_valid, pred_hit, pred_taken, pred_target);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    lk(32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL reset_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_lookup: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h", o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_counter_down();
    pred_t e, o;
    up(32'h40, 1'b1, 32'h100);
    lk(32'h40, 1'b1, 1'b1, 32'h100);
    up(32'h40, 1'b0, 32'h0);
    lk(32'h40, 1'b1, 1'b0, 32'h100);
    up(32'h40, 1'b0, 32'h0);
    lk(32'h40, 1'b1, 1'b0, 32'h100);
    up(32'h40, 1'b0, 32'h0);
    up(32'h40, 1'b1, 32'h100);
    lk(32'h40, 1'b1, 1'b0, 32'h100);
    @(negedge clk); #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL ctr_down_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL ctr_down: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h", o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_counter_up();
    pred_t e, o;
    do_flush();
    up(32'h40, 1'b1, 32'h100);
    up(32'h40, 1'b1, 32'h100);
    up(32'h40, 1'b1, 32'h180);
    up(32'h40, 1'b0, 32'h999);
    lk(32'h40, 1'b1, 1'b1, 32'h180);
    up(32'h40, 1'b0, 32'h0);
    lk(32'h40, 1'b1, 1'b0, 32'h180);
    @(negedge clk); #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL ctr_up_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL ctr_up: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h", o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_conflict();
    pred_t e, o;
    do_flush();
    up(32'h040, 1'b1, 32'h1000);
    up(32'h440, 1'b1, 32'h2000);
    lk(32'h040, 1'b1, 1'b1, 32'h1000);
    up(32'h840, 1'b1, 32'h3000);
    lk(32'h040, 1'b1, 1'b1, 32'h1000);
    lk(32'h440, 1'b0, 1'b0, 32'h0);
    lk(32'h840, 1'b1, 1'b1, 32'h3000);
    @(negedge clk); #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL conflict_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL conflict: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h", o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    pred_t e, o;
    do_flush();
    exp_q.push_back('{hit: 1'b0, taken: 1'b0, target: 32'h0});
    cyc(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0);
    lk(32'h80, 1'b1, 1'b1, 32'h500);
    up(32'hC0, 1'b0, 32'h777);
    lk(32'hC0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h", o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush();
    pred_t e, o;
    up(32'h040, 1'b1, 32'hA000);
    up(32'h044, 1'b1, 32'hA004);
    up(32'h048, 1'b1, 32'hA008);
    up(32'h04C, 1'b1, 32'hA00C);
    lk(32'h048, 1'b1, 1'b1, 32'hA008);
    exp_q.push_back('{hit: 1'b1, taken: 1'b1, target: 32'hA004});
    cyc(1'b1, 32'h044, 1'b1, 32'h200, 1'b1, 32'hABC, 1'b1);
    lk(32'h200, 1'b0, 1'b0, 32'h0);
    lk(32'h040, 1'b0, 1'b0, 32'h0);
    lk(32'h044, 1'b0, 1'b0, 32'h0);
    lk(32'h048, 1'b0, 1'b0, 32'h0);
    lk(32'h04C, 1'b0, 1'b0, 32'h0);
    lk(32'h080, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL flush_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL flush: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h", o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    pred_t e, o;
    up(32'h40, 1'b1, 32'h700);
    lk(32'h40, 1'b1, 1'b1, 32'h700);
    lookup_valid = 1'b1; lookup_pc = 32'h40;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    tests++;
    if (pred_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_pre: got pred_valid=%b, want 1", pred_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({pred_valid, pred_hit, pred_taken, pred_target} !== 35'd0) begin
      fails++;
      $display("FAIL mid_reset_async: got v=%b h=%b t=%b tgt=%h, want all 0", pred_valid, pred_hit, pred_taken, pred_target);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    lk(32'h40, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL mid_reset_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL mid_reset: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h", o.hit, o.taken, o.target, e.hit, e.taken, e.target);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_counter_down();
    test_counter_up();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
